mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Memory access sequencer between the datapath control unit and the word RAM.
//  Latches the bus address (MAR) and write data, drives the RAM's read/write strobes,
//  absorbs the RAM's 1-cycle synchronous read latency, and captures read data (MDR).
//  Gives the control unit a level request / one-cycle done handshake.
// PARAMETERS
//  BITS     32                 data word width
//  RAMSIZE  512                RAM depth in words
//  ADDR     $clog2(RAMSIZE)    RAM address width
//  ABITS    32                 datapath bus address width (ABITS >= ADDR)
// PORTS
//  clk          in   1      single clock; all state changes on rising edge
//  clear_n      in   1      reset, asynchronous, active-low
//  req_read     in   1      read request, level; sampled only in IDLE
//  req_write    in   1      write request, level; sampled only in IDLE
//  addr_in      in   ABITS  word address from bus
//  wdata_in     in   BITS   write data from bus
//  busy         out  1      state != IDLE
//  done         out  1      one-cycle completion pulse
//  err          out  1      completed request was rejected; valid with done
//  rdata_out    out  BITS   MDR: last successfully read word
//  ram_address  out  ADDR   to RAM address
//  ram_dataIn   out  BITS   to RAM dataIn
//  ram_read     out  1      to RAM read
//  ram_write    out  1      to RAM write
//  ram_dataOut  in   BITS   from RAM dataOut (updated on the edge where ram_read=1)
// BEHAVIOUR
//  - Reset (clear_n=0, immediate): state=IDLE, MAR=0, WDR=0, rdata_out=0, err=0.
//    busy/done/ram_read/ram_write=0. RAM contents are not cleared.
//  - States: IDLE, WR, RD, RCAP, DONE (encoding in shared include).
//    ram_* strobes and done/busy decode from the state register only (Moore outputs).
//  - Acceptance happens on the IDLE edge E0. Requests in any other state are ignored.
//    The control unit holds req until it sees done, then drops it in the done cycle.
//    A req still high on return to IDLE is accepted again.
//  - Classification at E0:
//    * Exactly one req, addr_in[ABITS-1:ADDR]==0: MAR<=addr_in[ADDR-1:0].
//      Write: also WDR<=wdata_in, go WR. Read: go RD.
//    * Both reqs high, or address out of range: err<=1, go DONE. No RAM strobe ever.
//  - Write: in WR, ram_write=1, ram_address=MAR, ram_dataIn=WDR. E1: RAM writes; go DONE.
//    done is high in the cycle after E1 (latency 1).
//  - Read: in RD, ram_read=1, ram_address=MAR. E1: RAM updates dataOut; go RCAP.
//    In RCAP, strobes=0. E2: rdata_out<=ram_dataOut; go DONE. done is high after E2 (latency 2).
//  - Successful accept clears err<=0. rdata_out changes only at RCAP->DONE.
//  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE. Back-to-back period:
//    write 3 cycles, read 4 cycles.
//  - ram_read and ram_write are never high together, and never high outside WR/RD.
//  - ram_address/ram_dataIn always drive MAR/WDR, stable through each strobe cycle.
//  - Reset asserted during WR before E1: write aborts, RAM unchanged.
//    Reset during RD/RCAP: no MDR update.
// STRUCTURE
//  - Shared include mem_ctrl_defs.vh: state encodings (3-bit localparams IDLE..DONE).
//    Shared by the control unit and the bench.
//  - No sub-module is required. MAR/WDR/MDR are plain registers in this module.
//  - Top level instantiates mem_ctrl next to ram with matching BITS/RAMSIZE.
// TESTING (bench: mem_ctrl + ram, 512x32)
//  1 Write 'h0000f7f7 to addr 85 -> ram_write high exactly 1 cycle, done 1 cycle after accept.
//    err=0, RAM[85]='h0000f7f7.
//  2 Read addr 85 -> ram_read 1 cycle; rdata_out='h0000f7f7 when done (2 cycles after accept).
//  3 Both reqs high, addr 4 -> no ram strobe, done after 1 cycle, err=1, rdata_out unchanged.
//  4 Read addr 'h200 (>=RAMSIZE) -> no strobe, err=1. Following read of addr 0 clears err.
//  5 Req held after done -> re-accepted on IDLE. Write then read to same addr back-to-back
//    returns the new data.
//  6 clear_n low in WR cycle (write 'hAAAA5555 to addr 7) -> ram_write drops at once.
//    RAM[7] keeps old value, state IDLE, outputs at reset values.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory access sequencer: FSM state encoding and request classification.
// Pure declarations, no latency; no flow control of its own.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_RCAP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_WRITE = 2'd1,
        REQ_READ  = 2'd2,
        REQ_BAD   = 2'd3
    } req_kind_t;

    // Conflicting strobes and out-of-range addresses both finish as rejected.
    function automatic req_kind_t classify(input logic rd, input logic wr, input logic in_range);
        if (!rd && !wr)
            return REQ_NONE;
        if ((rd && wr) || !in_range)
            return REQ_BAD;
        return wr ? REQ_WRITE : REQ_READ;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Control-unit side of the memory sequencer: level request in, busy/done/err/MDR out.
// Request is held by the master until done; the slave accepts only while idle.
interface mem_ctrl_if #(
    parameter int BITS  = 32,
    parameter int ABITS = 32
);
    logic             req_read;
    logic             req_write;
    logic [ABITS-1:0] addr_in;
    logic [BITS-1:0]  wdata_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [BITS-1:0]  rdata_out;

    modport master (
        output req_read, req_write, addr_in, wdata_in,
        input  busy, done, err, rdata_out
    );

    modport slave (
        input  req_read, req_write, addr_in, wdata_in,
        output busy, done, err, rdata_out
    );
endinterface

// File: rtl/mem_ctrl_ram.sv
// Single-port word RAM with synchronous write and 1-cycle registered read.
// Read data appears the cycle after read is strobed; always ready, no backpressure.
module ram #(
    parameter int BITS    = 32,
    parameter int RAMSIZE = 512,
    parameter int ADDR    = $clog2(RAMSIZE)
) (
    input  logic            clk,
    input  logic [ADDR-1:0] address,
    input  logic [BITS-1:0] dataIn,
    output logic [BITS-1:0] dataOut,
    input  logic            read,
    input  logic            write
);

    logic [BITS-1:0] mem [RAMSIZE];

    always_ff @(posedge clk) begin
        if (write)
            mem[address] <= dataIn;
        if (read)
            dataOut <= mem[address];
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory access sequencer: latches MAR/WDR, strobes the RAM, captures read data into MDR.
// Latency accept->done: write 2 cycles, read 3, rejected 1; back-to-back period write 3, read 4.
// Requests are sampled only in IDLE; the control unit holds req until done.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int BITS    = 32,
    parameter int RAMSIZE = 512,
    parameter int ADDR    = $clog2(RAMSIZE),
    parameter int ABITS   = 32
) (
    input  logic            clk,
    input  logic            clear_n,
    mem_ctrl_if.slave       cu,
    output logic [ADDR-1:0] ram_address,
    output logic [BITS-1:0] ram_dataIn,
    output logic            ram_read,
    output logic            ram_write,
    input  logic [BITS-1:0] ram_dataOut
);

    state_t          state;
    state_t          state_nxt;
    req_kind_t       kind;
    logic            in_range;

    logic [ADDR-1:0] mar;
    logic [BITS-1:0] wdr;
    logic [BITS-1:0] mdr;
    logic            err_q;

    logic            busy_c;
    logic            done_c;
    logic            rd_c;
    logic            wr_c;

    // Any bus address bit above the RAM address width means out of range.
    assign in_range = ((cu.addr_in >> ADDR) == '0);
    assign kind     = classify(cu.req_read, cu.req_write, in_range);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b1;
        done_c    = 1'b0;
        rd_c      = 1'b0;
        wr_c      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy_c = 1'b0;
                unique case (kind)
                    REQ_WRITE: state_nxt = ST_WR;
                    REQ_READ:  state_nxt = ST_RD;
                    REQ_BAD:   state_nxt = ST_DONE;
                    default:   state_nxt = ST_IDLE;
                endcase
            end
            ST_WR: begin
                wr_c      = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_RD: begin
                rd_c      = 1'b1;
                state_nxt = ST_RCAP;
            end
            ST_RCAP: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done_c    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy_c    = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            mar   <= '0;
            wdr   <= '0;
            mdr   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                unique case (kind)
                    REQ_WRITE: begin
                        mar   <= cu.addr_in[ADDR-1:0];
                        wdr   <= cu.wdata_in;
                        err_q <= 1'b0;
                    end
                    REQ_READ: begin
                        mar   <= cu.addr_in[ADDR-1:0];
                        err_q <= 1'b0;
                    end
                    REQ_BAD: begin
                        err_q <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            // RAM dataOut was refreshed on the RD edge; MDR samples it one edge later.
            if (state == ST_RCAP)
                mdr <= ram_dataOut;
        end
    end

    assign ram_address  = mar;
    assign ram_dataIn   = wdr;
    assign ram_read     = rd_c;
    assign ram_write    = wr_c;

    assign cu.busy      = busy_c;
    assign cu.done      = done_c;
    assign cu.err       = err_q;
    assign cu.rdata_out = mdr;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized scoreboard bench for mem_ctrl driving a 512x32 ram.
module tb_mem_ctrl;

    localparam int BITS    = 32;
    localparam int RAMSIZE = 512;
    localparam int ADDR    = 9;
    localparam int ABITS   = 32;

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR-1:0] ram_address;
    logic [BITS-1:0] ram_dataIn;
    logic [BITS-1:0] ram_dataOut;
    logic            ram_read;
    logic            ram_write;

    mem_ctrl_if #(.BITS(BITS), .ABITS(ABITS)) cu ();

    mem_ctrl #(.BITS(BITS), .RAMSIZE(RAMSIZE), .ADDR(ADDR), .ABITS(ABITS)) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .cu          (cu),
        .ram_address (ram_address),
        .ram_dataIn  (ram_dataIn),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .ram_dataOut (ram_dataOut)
    );

    ram #(.BITS(BITS), .RAMSIZE(RAMSIZE), .ADDR(ADDR)) u_ram (
        .clk     (clk),
        .address (ram_address),
        .dataIn  (ram_dataIn),
        .dataOut (ram_dataOut),
        .read    (ram_read),
        .write   (ram_write)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          busy_cyc;
        int          wr_strb;
        int          rd_strb;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] exp_mdr = '0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: counts busy/strobe cycles of each transaction and scores it at done.
    int busy_cnt = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (clear_n) begin
            check("strobe_overlap", 32'(ram_read & ram_write), 32'd0);
            if (!cu.busy) begin
                check("idle_strobes", {30'd0, ram_read, ram_write}, 32'd0);
                check("idle_done", 32'(cu.done), 32'd0);
                busy_cnt = 0;
                wr_cnt   = 0;
                rd_cnt   = 0;
            end else begin
                busy_cnt++;
                wr_cnt += int'(ram_write);
                rd_cnt += int'(ram_read);
                if (cu.done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done with empty queue, expected none (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("err", 32'(cu.err), 32'(e.err));
                        check("rdata_out", cu.rdata_out, e.rdata);
                        check("busy_cycles", busy_cnt, e.busy_cyc);
                        check("ram_write_cycles", wr_cnt, e.wr_strb);
                        check("ram_read_cycles", rd_cnt, e.rd_strb);
                    end
                end
            end
        end else begin
            busy_cnt = 0;
            wr_cnt   = 0;
            rd_cnt   = 0;
        end
    end

    // Computes the expected outcome, raises the request and waits (bounded) for done.
    // Returns at the done negedge with the request still asserted.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int done_cyc);
        exp_t e;
        if ((rd && wr) || a >= RAMSIZE) begin
            e = '{1'b1, exp_mdr, 1, 0, 0};
        end else if (wr) begin
            ref_mem[int'(a)] = d;
            e = '{1'b0, exp_mdr, 2, 1, 0};
        end else begin
            exp_mdr = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'hx;
            e = '{1'b0, exp_mdr, 3, 0, 1};
        end
        exp_q.push_back(e);
        cu.req_read  = rd;
        cu.req_write = wr;
        cu.addr_in   = a;
        cu.wdata_in  = d;
        done_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cu.done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in 20 cycles, expected done (addr %0h)", a);
        end
    endtask

    task automatic go_idle(input int n);
        cu.req_read  = 1'b0;
        cu.req_write = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int d1, d2, d3;
        logic        op_rd, op_wr;
        logic [31:0] a, d;
        int          sel;

        cu.req_read  = 1'b0;
        cu.req_write = 1'b0;
        cu.addr_in   = '0;
        cu.wdata_in  = '0;
        clear_n      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(cu.busy), 32'd0);
        check("rst_done", 32'(cu.done), 32'd0);
        check("rst_err", 32'(cu.err), 32'd0);
        check("rst_rdata", cu.rdata_out, 32'd0);
        check("rst_strobes", {30'd0, ram_read, ram_write}, 32'd0);
        check("rst_address", 32'(ram_address), 32'd0);
        check("rst_dataIn", ram_dataIn, 32'd0);
        clear_n = 1'b1;
        @(negedge clk);

        // Basic write, read back, conflicting request
        issue(1'b0, 1'b1, 32'd85, 32'h0000f7f7, d1);
        go_idle(1);
        issue(1'b1, 1'b0, 32'd85, 32'h0, d1);
        go_idle(1);
        issue(1'b1, 1'b1, 32'd4, 32'h0, d1);
        go_idle(1);

        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 1'b1, 32'(i), $urandom, d1);
            if (i % 2 == 0) go_idle(1);
        end
        go_idle(1);

        // Out of range read, then a good read clears err
        issue(1'b1, 1'b0, 32'h200, 32'h0, d1);
        issue(1'b1, 1'b0, 32'h0, 32'h0, d1);
        go_idle(1);

        // Held request re-accepted, then back-to-back write->read
        issue(1'b0, 1'b1, 32'd3, 32'h12345678, d1);
        issue(1'b0, 1'b1, 32'd3, 32'h12345678, d2);
        check("write_period", d2 - d1, 32'd3);
        issue(1'b1, 1'b0, 32'd3, 32'h0, d3);
        check("read_period", d3 - d2, 32'd4);
        go_idle(1);

        // Reset mid-write: strobe drops immediately and RAM keeps its old word
        issue(1'b1, 1'b1, 32'd4, 32'h0, d1);
        go_idle(1);
        cu.req_write = 1'b1;
        cu.addr_in   = 32'd7;
        cu.wdata_in  = 32'hAAAA5555;
        @(posedge clk);
        #1;
        check("wr_strobe", 32'(ram_write), 32'd1);
        check("wr_address", 32'(ram_address), 32'd7);
        check("wr_dataIn", ram_dataIn, 32'hAAAA5555);
        #2;
        clear_n = 1'b0;
        #1;
        check("abort_write", 32'(ram_write), 32'd0);
        check("abort_busy", 32'(cu.busy), 32'd0);
        check("abort_err", 32'(cu.err), 32'd0);
        check("abort_rdata", cu.rdata_out, 32'd0);
        check("abort_done", 32'(cu.done), 32'd0);
        cu.req_write = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        exp_mdr = '0;
        @(negedge clk);
        issue(1'b1, 1'b0, 32'd7, 32'h0, d1);
        go_idle(1);

        for (int n = 0; n < 80; n++) begin
            sel   = $urandom_range(0, 9);
            op_rd = (sel == 0) || (sel >= 5);
            op_wr = (sel <= 4);
            if ($urandom_range(0, 7) == 0)
                a = $urandom | 32'h200;
            else
                a = 32'($urandom_range(0, 15));
            d = $urandom;
            issue(op_rd, op_wr, a, d, d1);
            if ($urandom_range(0, 1) == 1)
                go_idle($urandom_range(1, 3));
        end
        go_idle(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
